consent_header_assembler: RTL and testbench
===========================================

CONSENT_HEADER_ASSEMBLER -- requirements
Module: consent_header_assembler

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 18: bytes per consent header (144 bits).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum idle cycles allowed between bytes inside a header.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-006 SHALL have port in_data  input  8  header byte, most-significant byte first.
REQ-007 SHALL have port in_sof  input  1  marks the first byte of a header.
REQ-008 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port consent_header  output  144  assembled header; this is the consent_header input of the downstream parser.
REQ-010 SHALL have port hdr_valid  output  1  consent_header is complete and stable.
REQ-011 SHALL have port hdr_ready  input  1  downstream accepts the header.
REQ-012 SHALL have port err_timeout  output  1  one-cycle pulse when a partial header is discarded on timeout.
REQ-013 SHALL have port err_framing  output  1  one-cycle pulse on a stray byte or a restart.
REQ-014 SHALL have port hdr_count  output  16  count of delivered headers, saturating.
REQ-015 SHALL have port err_count  output  8  count of err_timeout plus err_framing events, saturating.

Function
REQ-016 A byte SHALL transfer only on a cycle where in_valid=1 and in_ready=1; a header SHALL transfer only on a cycle where hdr_valid=1 and hdr_ready=1.
REQ-017 The FSM SHALL have three states: IDLE, COLLECT and HOLD; in_ready SHALL be 1 in IDLE and COLLECT and 0 in HOLD.
REQ-018 IDLE: an accepted byte with in_sof=1 SHALL be stored as byte 0 (bits [143:136]), set byte index to 1, and move to COLLECT.
REQ-019 IDLE: an accepted byte with in_sof=0 SHALL be dropped, pulse err_framing and remain in IDLE.
REQ-020 COLLECT: an accepted byte with in_sof=0 SHALL be stored at byte index k (bits [143-8k -: 8]) and increment the index.
REQ-021 COLLECT: an accepted byte with in_sof=1 SHALL discard the partial header, pulse err_framing, store the byte as byte 0 and set the index to 1.
REQ-022 When byte HDR_BYTES-1 is accepted, the FSM SHALL enter HOLD and assert hdr_valid on the next cycle (latency 1 cycle from the last byte).
REQ-023 HOLD: consent_header and hdr_valid SHALL remain stable until the header transfers; the FSM SHALL then return to IDLE and hdr_count SHALL increment.
REQ-024 The idle counter SHALL clear on every accepted byte and increment on every other COLLECT cycle.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL pulse err_timeout, clear the byte index and go to IDLE; the timeout SHALL lose to a byte accepted in the same cycle.
REQ-026 The idle counter SHALL stay at 0 in IDLE and HOLD, so HOLD never times out.
REQ-027 hdr_count and err_count SHALL saturate at all-ones; err_count SHALL increment once per error pulse.
REQ-028 consent_header SHALL hold its last value outside HOLD; downstream SHALL qualify it with hdr_valid.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, byte index 0, idle counter 0, consent_header 0, hdr_valid 0, err_timeout 0, err_framing 0, hdr_count 0 and err_count 0; in_ready SHALL be 1 once reset is released.
REQ-030 Reset during COLLECT or HOLD SHALL discard the header with no error pulse and no count change.

Structure
REQ-031 Package spiral_pkg SHALL hold HDR_BITS=144, HDR_BYTES=18 and the assembler state enum (IDLE, COLLECT, HOLD).
REQ-032 One sub-module, spiral_sat_counter (parameterised width, increment input, asynchronous active-low reset), SHALL implement hdr_count and err_count.

Verification
REQ-033 Send 18 back-to-back bytes CA FE BA BE 12 34 56 78 90 AB CD EF 00 11 22 33 44 55 with SOF on the first, hdr_ready=1 -> hdr_valid high exactly 1 cycle after the last byte, header = 144'hCAFEBABE_1234567890ABCDEF_001122334455, hdr_count=1.
REQ-034 Complete a header with hdr_ready=0 for 10 cycles -> in_ready=0 and the header stable for all 10 cycles; after hdr_ready=1, return to IDLE and hdr_count increments.
REQ-035 Send 5 bytes then idle for 255 cycles -> err_timeout pulses once, err_count=1, FSM in IDLE; the next SOF header assembles correctly.
REQ-036 Send 7 bytes then a byte with in_sof=1 plus 17 more -> one err_framing pulse, the delivered header starts with the restart byte.
REQ-037 Send 3 bytes without SOF while IDLE -> 3 err_framing pulses, err_count=3, no hdr_valid.
REQ-038 Assert reset=0 mid-COLLECT (byte 9) -> all outputs go to reset values immediately, without waiting for a clk edge, with no error pulse.

Source files
------------

// File: rtl/spiral_pkg.sv
// Shared constants and state encoding for the consent header assembler.
package spiral_pkg;

  localparam int HDR_BITS  = 144;
  localparam int HDR_BYTES = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } asm_state_e;

endpackage

// File: rtl/spiral_sat_counter.sv
// Event counter that increments on inc_i and sticks at all-ones.
module spiral_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/consent_header_assembler.sv
// Collects an MSB-first byte stream into one consent header and hands it
// downstream over a valid/ready pair, flagging stray bytes, restarts and stalls.
module consent_header_assembler #(
  parameter int HDR_BYTES      = 18,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [HDR_BYTES*8-1:0] consent_header,
  output logic                   hdr_valid,
  input  logic                   hdr_ready,
  output logic                   err_timeout,
  output logic                   err_framing,
  output logic [15:0]            hdr_count,
  output logic [7:0]             err_count,
  output logic [1:0]             dbg_state
);

  import spiral_pkg::*;

  localparam int HW = HDR_BYTES * 8;
  localparam int XW = $clog2(HDR_BYTES);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [XW-1:0] LAST_IDX = XW'(HDR_BYTES - 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CYCLES - 1);

  // Valid/ready: a byte moves when in_valid && in_ready, a header moves when
  // hdr_valid && hdr_ready; neither side may retract a raised valid.
  asm_state_e    state_q, state_d;
  logic [XW-1:0] idx_q, idx_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [HW-1:0] asm_q, asm_d;
  logic [HW-1:0] hdr_q, hdr_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_framing_q, err_framing_d;
  logic          accept;
  logic [HW-1:0] asm_shift;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  // Bytes arrive MSB-first, so shifting left lands byte 0 at the top once
  // the final byte is in; any bytes from before a restart fall off the end.
  assign asm_shift = {asm_q[HW-9:0], in_data};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    idle_d        = '0;
    asm_d         = asm_q;
    hdr_d         = hdr_q;
    err_timeout_d = 1'b0;
    err_framing_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            asm_d   = asm_shift;
            idx_d   = XW'(1);
            state_d = COLLECT;
          end else begin
            err_framing_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_d = asm_shift;
          if (in_sof) begin
            err_framing_d = 1'b1;
            idx_d         = XW'(1);
          end else if (idx_q == LAST_IDX) begin
            hdr_d   = asm_shift;
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + XW'(1);
          end
        end else if (idle_q == IDLE_LIM) begin
          err_timeout_d = 1'b1;
          idx_d         = '0;
          state_d       = IDLE;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      HOLD: begin
        if (hdr_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      idle_q        <= '0;
      asm_q         <= '0;
      hdr_q         <= '0;
      err_timeout_q <= 1'b0;
      err_framing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      idle_q        <= idle_d;
      asm_q         <= asm_d;
      hdr_q         <= hdr_d;
      err_timeout_q <= err_timeout_d;
      err_framing_q <= err_framing_d;
    end
  end

  assign consent_header = hdr_q;
  assign hdr_valid      = (state_q == HOLD);
  assign err_timeout    = err_timeout_q;
  assign err_framing    = err_framing_q;
  assign dbg_state      = state_q;

  spiral_sat_counter #(.W(16)) u_hdr_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (hdr_valid && hdr_ready),
    .count_o (hdr_count)
  );

  spiral_sat_counter #(.W(8)) u_err_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (err_timeout_d || err_framing_d),
    .count_o (err_count)
  );

endmodule

// File: tb/tb_consent_header_assembler.sv
// Directed and randomized bench for consent_header_assembler against a
// byte-queue reference model.
module tb_consent_header_assembler;
  import spiral_pkg::*;

  localparam int HB      = 18;
  localparam int HW      = HB * 8;
  localparam int TMO     = 255;
  localparam int WAIT_LIM = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_sof, in_ready, hdr_valid, hdr_ready;
  logic [7:0]    in_data;
  logic [HW-1:0] consent_header;
  logic          err_timeout, err_framing;
  logic [15:0]   hdr_count;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state;

  consent_header_assembler #(.HDR_BYTES(HB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_ready       (in_ready),
    .consent_header (consent_header),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdr_ready),
    .err_timeout    (err_timeout),
    .err_framing    (err_framing),
    .hdr_count      (hdr_count),
    .err_count      (err_count),
    .dbg_state      (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: partial header as a byte queue, completed headers queued
  logic [HW-1:0] exp_q[$];
  logic [7:0]    part_q[$];
  bit            collecting = 0;
  int            gap = 0;
  int            exp_fr = 0, exp_to = 0;
  int            exp_err_cnt = 0, exp_hdr_cnt = 0;

  function automatic void bump_err();
    if (exp_err_cnt < 255) exp_err_cnt++;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic sof);
    logic [HW-1:0] h;
    gap = 0;
    if (sof) begin
      if (collecting) begin exp_fr++; bump_err(); end
      part_q.delete();
      part_q.push_back(b);
      collecting = 1;
    end else if (!collecting) begin
      exp_fr++;
      bump_err();
    end else begin
      part_q.push_back(b);
    end
    if (collecting && part_q.size() == HB) begin
      h = '0;
      foreach (part_q[i]) h = {h[HW-9:0], part_q[i]};
      exp_q.push_back(h);
      if (exp_hdr_cnt < 65535) exp_hdr_cnt++;
      collecting = 0;
      part_q.delete();
    end
  endfunction

  function automatic void model_idle(input int n);
    if (collecting) begin
      gap += n;
      if (gap >= TMO) begin
        exp_to++;
        bump_err();
        collecting = 0;
        part_q.delete();
        gap = 0;
      end
    end
  endfunction

  // scoreboard: delivered headers and observed error pulses
  int obs_fr = 0, obs_to = 0;
  always @(negedge clk) begin
    if (err_framing === 1'b1) obs_fr++;
    if (err_timeout === 1'b1) obs_to++;
    if (hdr_valid === 1'b1 && hdr_ready === 1'b1) begin
      if (exp_q.size() == 0) check("hdr_unexpected", 160'(consent_header), 160'hDEAD);
      else check("hdr_delivered", 160'(consent_header), 160'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic sof);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_sof   = sof;
    while (in_ready !== 1'b1 && waited < WAIT_LIM) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= WAIT_LIM) begin
      total++;
      bad++;
      $error("FAIL in_ready_wait observed=0 expected=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    model_byte(b, sof);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    model_idle(n);
  endtask

  task automatic send_rand_hdr();
    for (int i = 0; i < HB; i++) send_byte(8'($urandom), i == 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err_count"}, 160'(err_count), 160'(exp_err_cnt));
    check({tag, "_hdr_count"}, 160'(hdr_count), 160'(exp_hdr_cnt));
    check({tag, "_framing_pulses"}, 160'(obs_fr), 160'(exp_fr));
    check({tag, "_timeout_pulses"}, 160'(obs_to), 160'(exp_to));
  endtask

  logic [7:0]    vec [HB];
  logic [HW-1:0] held;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; hdr_ready = 1'b1;
    vec = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34, 8'h56, 8'h78, 8'h90,
            8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // reset values
    #12;
    check("rst_hdr_valid", 160'(hdr_valid), 160'(0));
    check("rst_header", 160'(consent_header), 160'(0));
    check("rst_state", 160'(dbg_state), 160'(IDLE));
    check("rst_err_pulses", 160'({err_timeout, err_framing}), 160'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_in_ready", 160'(in_ready), 160'(1));
    check_counts("rst");

    // known vector, back-to-back bytes
    for (int i = 0; i < HB - 1; i++) send_byte(vec[i], i == 0);
    check("vec_valid_before_last", 160'(hdr_valid), 160'(0));
    send_byte(vec[HB-1], 1'b0);
    check("vec_valid_lat1", 160'(hdr_valid), 160'(1));
    check("vec_header", 160'(consent_header),
          160'(144'hCAFEBABE_1234567890ABCDEF_001122334455));
    @(posedge clk); #1;
    check("vec_back_idle", 160'(dbg_state), 160'(IDLE));
    check("vec_hdr_count", 160'(hdr_count), 160'(1));

    // downstream back-pressure for 10 cycles
    hdr_ready = 1'b0;
    send_rand_hdr();
    held = exp_q[$];
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", 160'(in_ready), 160'(0));
      check("bp_valid", 160'(hdr_valid), 160'(1));
      check("bp_header_stable", 160'(consent_header), 160'(held));
      @(posedge clk); #1;
    end
    hdr_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", 160'(dbg_state), 160'(IDLE));
    check("bp_hdr_count", 160'(hdr_count), 160'(2));

    // timeout: 254 idle cycles is still collecting, the 255th discards
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 0);
    idle(TMO - 1);
    check("tmo_not_yet", 160'(dbg_state), 160'(COLLECT));
    check("tmo_no_pulse", 160'(err_timeout), 160'(0));
    idle(1);
    check("tmo_pulse", 160'(err_timeout), 160'(1));
    check("tmo_state_idle", 160'(dbg_state), 160'(IDLE));
    check("tmo_err_count", 160'(err_count), 160'(1));
    idle(1);
    check("tmo_pulse_one_cycle", 160'(err_timeout), 160'(0));
    send_rand_hdr();
    idle(2);
    check_counts("tmo");

    // restart after 7 bytes
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), i == 0);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < HB - 1; i++) send_byte(8'($urandom), 1'b0);
    check("restart_first_byte", 160'(consent_header[HW-1 -: 8]), 160'(8'h5A));
    idle(2);
    check_counts("restart");

    // stray bytes while idle
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    idle(2);
    check("stray_no_valid", 160'(hdr_valid), 160'(0));
    check_counts("stray");

    // error counter saturation
    for (int i = 0; i < 260; i++) send_byte(8'($urandom), 1'b0);
    idle(2);
    check("err_count_sat", 160'(err_count), 160'(8'hFF));
    check_counts("sat");

    // randomized traffic: gaps, stray bytes, restarts, occasional timeouts
    for (int h = 0; h < 8; h++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
      for (int i = 0; i < HB; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) idle(TMO + $urandom_range(0, 5));
        send_byte(8'($urandom), (i == 0) || ($urandom_range(0, 29) == 0));
      end
    end
    idle(3);
    check_counts("rand");
    check("rand_all_delivered", 160'(exp_q.size()), 160'(0));

    // asynchronous reset in the middle of a header
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), i == 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 160'(dbg_state), 160'(IDLE));
    check("arst_err_count", 160'(err_count), 160'(0));
    check("arst_hdr_count", 160'(hdr_count), 160'(0));
    check("arst_header", 160'(consent_header), 160'(0));
    check("arst_outputs", 160'({hdr_valid, err_timeout, err_framing}), 160'(0));
    collecting = 0; part_q.delete(); gap = 0; exp_err_cnt = 0; exp_hdr_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    send_rand_hdr();
    idle(3);
    check_counts("arst");
    check("final_all_delivered", 160'(exp_q.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
